// File: rtl/hwf_kernel_stream_pkg.sv
// Shared types and constants for the shift-add exponential kernel engine.
package hwf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SCALE,
    ST_RANGE,
    ST_ITER,
    ST_DONE
  } hwf_state_e;

  localparam int unsigned LN2_Q88 = 177;

  // round(256 * -ln(1 - 2^-i)); entry 0 is never addressed
  localparam logic [15:0] LOG_LUT_Q88 [0:15] = '{
    16'd0,   16'd177, 16'd74, 16'd34, 16'd17, 16'd8, 16'd4, 16'd2,
    16'd1,   16'd1,   16'd0,  16'd0,  16'd0,  16'd0, 16'd0, 16'd0
  };

  function automatic int unsigned acc_width(input int unsigned xlen,
                                            input int unsigned npix,
                                            input bit          l2);
    return l2 ? (2 * xlen + $clog2(npix)) : (xlen + $clog2(npix));
  endfunction

endpackage

// File: rtl/hwf_kernel_stream_if.sv
// Handshake bundle for hwf_kernel_stream: start/Bi command, pixel stream in, result stream out.
interface hwf_kernel_stream_if #(
  parameter int XLEN_PIXEL = 8,
  parameter int LANES      = 4
);
  logic                          start;
  logic [2*XLEN_PIXEL-1:0]       Bi;
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*XLEN_PIXEL-1:0]   x_test;
  logic [LANES*XLEN_PIXEL-1:0]   x_sv;
  logic                          out_valid;
  logic                          out_ready;
  logic [2*XLEN_PIXEL-1:0]       hwf_out;
  logic                          busy;

  modport master (
    output start, Bi, in_valid, x_test, x_sv, out_ready,
    input  in_ready, out_valid, hwf_out, busy
  );

  modport slave (
    input  start, Bi, in_valid, x_test, x_sv, out_ready,
    output in_ready, out_valid, hwf_out, busy
  );
endinterface

// File: rtl/hwf_kernel_stream_log_lut.sv
// Combinational ROM: iteration index i -> L[i] = -ln(1 - 2^-i) in Q8.8.
module hwf_log_lut
  import hwf_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [3:0]   idx_i,
  output logic [W-1:0] l_o
);
  always_comb l_o = W'(LOG_LUT_Q88[idx_i]);
endmodule

// File: rtl/hwf_kernel_stream.sv
// Kernel engine K = Bi * exp(-gamma * dist), multiplier-free exponential.
// Define HWF_L2_NORM_EN for squared-L2 distance (RBF); default is L1 (Laplacian).
module hwf_kernel_stream
  import hwf_pkg::*;
#(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 784,
  parameter int LANES         = 4,
  parameter int ITERATOR      = 8,
  parameter int GAMMA_SHIFT   = 4
) (
  input logic               clk,
  input logic               rst,
  hwf_kernel_stream_if.slave bus
);
`ifdef HWF_L2_NORM_EN
  localparam bit L2_EN = 1'b1;
`else
  localparam bit L2_EN = 1'b0;
`endif
  localparam int ACC_W  = acc_width(XLEN_PIXEL, NUM_OF_PIXELS, L2_EN);
  localparam int RW     = 2 * XLEN_PIXEL;
  localparam int BEATS  = NUM_OF_PIXELS / LANES;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int N_W    = $clog2(RW + 1);

  localparam logic [RW-1:0]     LN2       = RW'(LN2_Q88);
  localparam logic [N_W-1:0]    N_MAX     = N_W'(RW);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [3:0]        ITER_LAST = 4'(ITERATOR);

  hwf_state_e          state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [RW-1:0]       e_q, e_d;
  logic [RW-1:0]       b_q, b_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [3:0]          i_q, i_d;
  logic [RW-1:0]       hwf_out_q, hwf_out_d;

  logic [ACC_W-1:0]            lane_term [LANES];
  logic [ACC_W-1:0]            beat_sum;
  logic [ACC_W+XLEN_PIXEL-1:0] e_wide;
  logic [RW-1:0]               e_sat;
  logic [RW-1:0]               lut_l;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [XLEN_PIXEL-1:0] pix_sv, pix_test, diff;
    assign pix_sv   = bus.x_sv[gi*XLEN_PIXEL +: XLEN_PIXEL];
    assign pix_test = bus.x_test[gi*XLEN_PIXEL +: XLEN_PIXEL];
    assign diff     = (pix_sv >= pix_test) ? (pix_sv - pix_test) : (pix_test - pix_sv);
`ifdef HWF_L2_NORM_EN
    logic [2*XLEN_PIXEL-1:0] sq;
    assign sq            = {{XLEN_PIXEL{1'b0}}, diff} * {{XLEN_PIXEL{1'b0}}, diff};
    assign lane_term[gi] = ACC_W'(sq);
`else
    assign lane_term[gi] = ACC_W'(diff);
`endif
  end

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) beat_sum = beat_sum + lane_term[l];
  end

  // Distance to Q8.8, scaled by gamma = 2^-GAMMA_SHIFT, clamped to the E range
  assign e_wide = {acc_q, {XLEN_PIXEL{1'b0}}} >> GAMMA_SHIFT;
  assign e_sat  = ((e_wide >> RW) != '0) ? '1 : e_wide[RW-1:0];

  hwf_log_lut #(.W(RW)) u_lut (
    .idx_i (i_q),
    .l_o   (lut_l)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    beat_d    = beat_q;
    e_d       = e_q;
    b_d       = b_q;
    n_d       = n_q;
    i_d       = i_q;
    hwf_out_d = hwf_out_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          b_d     = bus.Bi;
          acc_d   = '0;
          beat_d  = '0;
          e_d     = '0;
          n_d     = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          acc_d  = acc_q + beat_sum;
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_LAST) state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        e_d     = e_sat;
        state_d = ST_RANGE;
      end
      ST_RANGE: begin
        // Pull out whole ln2 multiples as right shifts; 2*XLEN halvings empties B
        if (e_q >= LN2 && n_q < N_MAX) begin
          e_d = e_q - LN2;
          b_d = b_q >> 1;
          n_d = n_q + 1'b1;
        end else if (n_q == N_MAX) begin
          b_d       = '0;
          hwf_out_d = '0;
          state_d   = ST_DONE;
        end else if (ITERATOR == 0) begin
          hwf_out_d = b_q;
          state_d   = ST_DONE;
        end else begin
          i_d     = 4'd1;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        if (e_q >= lut_l) begin
          e_d = e_q - lut_l;
          b_d = b_q - (b_q >> i_q);
        end
        i_d = i_q + 1'b1;
        if (i_q == ITER_LAST) begin
          hwf_out_d = b_d;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      beat_q    <= '0;
      e_q       <= '0;
      b_q       <= '0;
      n_q       <= '0;
      i_q       <= '0;
      hwf_out_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      beat_q    <= beat_d;
      e_q       <= e_d;
      b_q       <= b_d;
      n_q       <= n_d;
      i_q       <= i_d;
      hwf_out_q <= hwf_out_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.hwf_out   = hwf_out_q;

endmodule

// File: doc/hwf_kernel_stream.md
# hwf_kernel_stream

Streaming, parametrised hardware-friendly kernel engine for the cascaded SVM. It computes K = Bi·exp(−γ·‖x_sv − x_test‖) for one test vector against one support vector. Pixels arrive LANES per beat over a valid/ready stream, and the exponential is evaluated with a range-reduced shift-add iteration that uses no multipliers. One instance sits per SV slot, between the SV memory reader and the decision-function accumulator.

## Interface
- XLEN_PIXEL, 8: pixel width; the result is Q(XLEN_PIXEL).(XLEN_PIXEL), 2·XLEN_PIXEL bits.
- NUM_OF_PIXELS, 784: vector length; must be a multiple of LANES.
- LANES, 4: pixels consumed per accepted beat.
- ITERATOR, 8: shift-add iterations, i = 1..ITERATOR, with ITERATOR ≤ 15.
- GAMMA_SHIFT, 4: γ = 2^−GAMMA_SHIFT, valid range 0..15.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a kernel evaluation; honoured only in IDLE.
- Bi  in  2·XLEN_PIXEL  Q8.8 scale; latched when start is accepted.
- in_valid  in  1  the pixel beat is valid.
- in_ready  out  1  the engine accepts a beat.
- x_test  in  LANES·XLEN_PIXEL  test pixels; lane 0 is in the LSBs.
- x_sv  in  LANES·XLEN_PIXEL  support-vector pixels, in the same lane order.
- out_valid  out  1  hwf_out is valid.
- out_ready  in  1  the consumer takes the result.
- hwf_out  out  2·XLEN_PIXEL  Q8.8 kernel value.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE → ACCUM → SCALE → RANGE → ITER → DONE → IDLE.
- IDLE: when start = 1, latch B = Bi, clear the accumulator, beat counter, E and n, then go to ACCUM.
- ACCUM:
  - in_ready = 1.
  - On each edge with in_valid & in_ready, add Σ|x_sv[l] − x_test[l]| over all lanes. Each difference is unsigned: the smaller value is subtracted from the larger.
  - After NUM_OF_PIXELS/LANES beats, go to SCALE.
  - Accumulator width ACC_W = XLEN_PIXEL + clog2(NUM_OF_PIXELS); it cannot overflow.
- SCALE: E = (D << 8) >> GAMMA_SHIFT, saturated to 0xFFFF (Q8.8).
- RANGE:
  - Each cycle, if E ≥ LN2 (177) and n < 2·XLEN_PIXEL: E −= 177, B >>= 1 (logical), n += 1.
  - Else if n == 2·XLEN_PIXEL: B = 0 and go directly to DONE.
  - Else go to ITER.
- ITER: for i = 1..ITERATOR, one step per cycle. If E ≥ L[i]: E −= L[i], B −= B >> i. Otherwise B and E are unchanged.
- L[i] = round(256·−ln(1 − 2^−i)):
  - i = 1..5: 177, 74, 34, 17, 8.
  - i = 6..9: 4, 2, 1, 1.
  - i ≥ 10: 0.
- DONE:
  - out_valid = 1 and hwf_out = B, both held stable until out_ready.
  - On out_valid & out_ready, return to IDLE.
  - hwf_out keeps its value until the next result.
- start in any state other than IDLE is ignored. Beats offered outside ACCUM are not consumed (in_ready = 0).
- Reset values: in_ready = 0, out_valid = 0, busy = 0, hwf_out = 0, FSM in IDLE. An rst during any state aborts the evaluation immediately; no partial result is produced.

## Timing
- An accepted start moves the FSM to ACCUM on the same edge. in_ready is high from the next cycle.
- Normal path: out_valid rises n + ITERATOR + 2 edges after the last accepting edge. That is SCALE 1 + RANGE n+1 + ITER ITERATOR.
- Saturation path: out_valid rises 2·XLEN_PIXEL + 2 edges after the last accepting edge.
- With in_valid held high and out_ready high, throughput is one result per NUM_OF_PIXELS/LANES + n + ITERATOR + 4 cycles.
- out_ready is sampled only in DONE. A start in the same cycle as the DONE→IDLE handshake is ignored.

## Configuration
- HWF_L2_NORM_EN:
  - Defined: the distance is squared L2, Σ(x_sv − x_test)², giving an RBF kernel. ACC_W becomes 2·XLEN_PIXEL + clog2(NUM_OF_PIXELS), and SCALE saturates identically.
  - Undefined: L1 distance, giving a Laplacian kernel.

## Structure
- Package hwf_pkg holds:
  - the state enum;
  - LN2_Q88 = 177;
  - the function acc_width(XLEN_PIXEL, NUM_OF_PIXELS, l2);
  - the L[i] table constant.
- Sub-module hwf_log_lut is a combinational ROM, index i → L[i] in Q8.8, shared by the ITER datapath.

## Test plan
- x_test = x_sv, Bi = 0x0100 → D = 0, n = 0, no ITER step taken, hwf_out = 0x0100, latency ITERATOR + 2 after the last beat.
- GAMMA_SHIFT = 8, one pixel difference of 177, Bi = 0x0100 → one RANGE step, E = 0, hwf_out = 0x0080.
- GAMMA_SHIFT = 8, one pixel difference of 74, Bi = 0x0100 → only i = 2 taken, hwf_out = 0x00C0.
- x_test all 0, x_sv all 255, GAMMA_SHIFT = 4 → E = 0xFFFF, n reaches 16, hwf_out = 0x0000 on the saturation path.
- in_valid toggling 1/0, and out_ready held low 5 cycles in DONE → exactly 196 beats consumed (784/4), result unchanged, out_valid held for the 5 cycles.
- rst pulsed mid-ACCUM, then a fresh identical-vector run → outputs at reset values immediately, and the second run yields 0x0100.
